// File: rtl/aes_key_sched_ctrl_pkg.sv
// Shared definitions for the AES-128 key-schedule controller slice.
// Holds the AES-128 geometry constants, the controller FSM encoding and
// a GF(2^8) multiply helper used by the S-box.
package aes_key_sched_ctrl_pkg;

  localparam int AES_NR     = 10;
  localparam int AES_KEY_W  = 128;
  localparam int AES_WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1
  } state_t;

  // Multiply in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_add_rcon.sv
// AddRcon: round-constant lookup for AES-128 key expansion.
// Ports: count - round counter (1..10); rcon - Rcon word, constant in the top byte.
// Count values outside 1..10 return zero; the controller never produces them.
module aes_add_rcon #(
  parameter int CNT_W = 4
) (
  input  logic [CNT_W-1:0] count,
  output logic [31:0]      rcon
);

  always_comb begin
    rcon = 32'h0000_0000;
    case (count)
      CNT_W'(1):  rcon = 32'h0100_0000;
      CNT_W'(2):  rcon = 32'h0200_0000;
      CNT_W'(3):  rcon = 32'h0400_0000;
      CNT_W'(4):  rcon = 32'h0800_0000;
      CNT_W'(5):  rcon = 32'h1000_0000;
      CNT_W'(6):  rcon = 32'h2000_0000;
      CNT_W'(7):  rcon = 32'h4000_0000;
      CNT_W'(8):  rcon = 32'h8000_0000;
      CNT_W'(9):  rcon = 32'h1b00_0000;
      CNT_W'(10): rcon = 32'h3600_0000;
      default:    rcon = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/aes_key_word_gen.sv
// Combinational AES-128 next-round-key generator.
// Ports: prev_key - round key i, w[4i] in [127:96]; rcon - Rcon word for the
// round being produced; next_key - round key i+1.
module aes_key_word_gen
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic [AES_KEY_W-1:0]  prev_key,
  input  logic [AES_WORD_W-1:0] rcon,
  output logic [AES_KEY_W-1:0]  next_key
);

  logic [AES_WORD_W-1:0] w0, w1, w2, w3;
  logic [AES_WORD_W-1:0] rot, sub, t;
  logic [AES_WORD_W-1:0] n0, n1, n2, n3;

  assign w0 = prev_key[127:96];
  assign w1 = prev_key[95:64];
  assign w2 = prev_key[63:32];
  assign w3 = prev_key[31:0];

  // RotWord: left rotate by one byte.
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (rot[8*g +: 8]),
      .dout (sub[8*g +: 8])
    );
  end

  assign t  = sub ^ rcon;
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign next_key = {n0, n1, n2, n3};

endmodule

// File: rtl/aes_sbox.sv
// AES forward S-box (combinational).
// Ports: din - input byte; dout - substituted byte.
// The multiplicative inverse is formed as din^254 (square-and-multiply);
// din=0 naturally maps to inverse 0, then the affine transform is applied.
module aes_sbox
  import aes_key_sched_ctrl_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  logic [7:0] pw;
  logic [7:0] inv;

  always_comb begin
    pw  = din;
    inv = 8'h01;
    // inv = din^2 * din^4 * ... * din^128 = din^254
    for (int i = 1; i < 8; i++) begin
      pw  = gf_mul(pw, pw);
      inv = gf_mul(inv, pw);
    end
    dout = inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// Iterative AES-128 key-expansion controller.
// Latches a cipher key on start and presents round keys 0..10, advancing one
// round per accepted handshake.
// Ports:
//   clk, rst_n      - clock, synchronous active-low reset
//   start, key_in   - begin expansion with key_in (accepted only in IDLE)
//   rk_ready        - consumer accepts the current round key
//   rk_valid        - round_key / round_idx are valid
//   round_key       - current round key, w[4i] in [127:96]
//   round_idx       - index of round_key, 0..10
//   busy            - expansion in progress
//   done            - one-cycle pulse after round key 10 is accepted
// Handshake: a transfer happens on a rising edge where rk_valid && rk_ready.
// While rk_valid && !rk_ready the round key and index are held unchanged;
// rk_ready has no effect while rk_valid is low.
module aes_key_sched_ctrl
  import aes_key_sched_ctrl_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [AES_KEY_W-1:0] key_in,
  input  logic                 rk_ready,
  output logic                 rk_valid,
  output logic [AES_KEY_W-1:0] round_key,
  output logic [3:0]           round_idx,
  output logic                 busy,
  output logic                 done
);

  localparam logic [3:0]       LAST_IDX = 4'(NR);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NR);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [AES_KEY_W-1:0]   key_n, gen_key;
  logic [3:0]             idx_n;
  logic                   valid_n, busy_n, done_n;
  logic [AES_WORD_W-1:0]  rcon;

  aes_add_rcon #(.CNT_W(CNT_W)) u_rcon (
    .count (cnt),
    .rcon  (rcon)
  );

  aes_key_word_gen u_word_gen (
    .prev_key (round_key),
    .rcon     (rcon),
    .next_key (gen_key)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      round_key <= '0;
      round_idx <= '0;
      rk_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      round_key <= key_n;
      round_idx <= idx_n;
      rk_valid  <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    key_n   = round_key;
    idx_n   = round_idx;
    valid_n = rk_valid;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          key_n   = key_in;
          idx_n   = 4'd0;
          cnt_n   = CNT_W'(1);
          valid_n = 1'b1;
          busy_n  = 1'b1;
          state_n = ST_EXPAND;
        end
      end
      ST_EXPAND: begin
        if (rk_valid && rk_ready) begin
          if (round_idx == LAST_IDX) begin
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
            state_n = ST_IDLE;
          end else begin
            key_n = gen_key;
            idx_n = round_idx + 4'd1;
            // cnt has already driven the last Rcon when it reaches NR; hold it
            // there so the lookup never leaves 1..NR.
            cnt_n = (cnt == LAST_CNT) ? cnt : cnt + CNT_W'(1);
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic         rk_ready = 1'b0;
  logic         rk_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         busy;
  logic         done;

  int checks = 0;
  int failures = 0;

  logic [131:0] exp_q[$];
  logic [127:0] captured[0:10];
  logic [7:0]   sbox_t[256];
  int  cyc = 0;
  int  done_count = 0;
  int  done_cyc = 0;
  int  first_valid_cyc = 0;
  bit  pending_done = 0;
  bit  prev_valid = 0;

  localparam logic [127:0] KEY_A1  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_SEQ = 128'h000102030405060708090a0b0c0d0e0f;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  aes_key_sched_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .rk_ready  (rk_ready),
    .rk_valid  (rk_valid),
    .round_key (round_key),
    .round_idx (round_idx),
    .busy      (busy),
    .done      (done)
  );

  // reference model: FIPS-197 key expansion over a word array
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sbox_t[x] = s;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  task automatic push_schedule(input logic [127:0] key);
    logic [31:0] w[44];
    logic [31:0] temp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = sub_word({temp[23:0], temp[31:24]}) ^ {rc, 24'h000000};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int r = 0; r <= 10; r++)
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
  endtask

  task automatic check(input string name, input logic [131:0] act, input logic [131:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        exp_q.delete();
        pending_done = 0;
        prev_valid = 0;
      end else begin
        if (pending_done) begin
          check("done_pulse", 132'(done), 132'(1));
          pending_done = 0;
        end else begin
          check("done_spurious", 132'(done), 132'(0));
        end
        if (done) begin
          done_count++;
          done_cyc = cyc;
        end
        check("busy", 132'(busy), 132'(exp_q.size() != 0));
        check("rk_valid", 132'(rk_valid), 132'(exp_q.size() != 0));
        if (rk_valid && !prev_valid) first_valid_cyc = cyc;
        prev_valid = rk_valid;
        if (rk_valid && exp_q.size() != 0) begin
          check("round_key_idx", {round_idx, round_key}, exp_q[0]);
          if (rk_ready) begin
            captured[exp_q[0][131:128]] = round_key;
            if (exp_q[0][131:128] == 4'd10) pending_done = 1;
            void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  // driver tasks
  task automatic start_key(input logic [127:0] k);
    @(posedge clk); #1;
    start = 1'b1;
    key_in = k;
    @(posedge clk); #1;
    start = 1'b0;
    for (int r = 0; r <= 10; r++) captured[r] = '0;
    push_schedule(k);
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0;
    int c;
    d0 = done_count;
    c = 0;
    while (done_count == d0 && c < bound) begin
      @(negedge clk);
      c++;
    end
    check(name, 132'(done_count != d0), 132'(1));
  endtask

  task automatic wait_idx(input logic [3:0] idx);
    int c;
    c = 0;
    while (!(rk_valid && round_idx == idx) && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
  endtask

  initial begin
    int d0;
    int c;
    build_sbox();

    // reset
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_values", {rk_valid, busy, done, round_idx, round_key}, '0);

    // idle: ready high, no start
    rk_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      check("idle_quiet", 132'({rk_valid, busy, done}), 132'(0));
    end

    // FIPS-197 A.1 schedule with ready held high
    start_key(KEY_A1);
    wait_done(40, "a1_done_timeout");
    check("a1_round0", 132'(captured[0]), 132'(KEY_A1));
    check("a1_round1", 132'(captured[1]), 132'(128'ha0fafe1788542cb123a339392a6c7605));
    check("a1_round10", 132'(captured[10]), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    check("a1_latency", 132'(done_cyc - first_valid_cyc), 132'(11));

    // backpressure at round 3
    start_key(KEY_A1);
    wait_idx(4'd3);
    rk_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_hold", {round_idx, round_key}, {4'd3, 128'h3d80477d4716fe3e1e237e446d7a883b});
      @(posedge clk); #1;
    end
    rk_ready = 1'b1;
    wait_done(40, "stall_done_timeout");
    check("stall_round10", 132'(captured[10]), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // start during expansion is ignored
    start_key(KEY_A1);
    wait_idx(4'd5);
    start = 1'b1;
    key_in = '0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(40, "midstart_done_timeout");
    check("midstart_round10", 132'(captured[10]), 132'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // reset mid-expansion
    start_key(KEY_A1);
    wait_idx(4'd6);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("midreset_values", {rk_valid, busy, done, round_idx, round_key}, '0);
    start_key(KEY_SEQ);
    wait_done(40, "seq_done_timeout");
    check("seq_round10", 132'(captured[10]), 132'(128'h13111d7fe3944a17f307a78b4d2b30c5));

    // start coinciding with the final handshake is ignored
    start_key(KEY_SEQ);
    wait_idx(4'd10);
    d0 = done_count;
    start = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("final_start_ignored", 132'({rk_valid, busy}), 132'(0));
    end
    check("final_done_once", 132'(done_count - d0), 132'(1));

    // randomized keys, random ready, random ignored start pulses
    for (int k = 0; k < 50; k++) begin
      rk_ready = ($urandom_range(0, 99) < 60);
      start_key({$urandom, $urandom, $urandom, $urandom});
      d0 = done_count;
      c = 0;
      while (done_count == d0 && c < 400) begin
        @(posedge clk); #1;
        rk_ready = ($urandom_range(0, 99) < 60);
        if (exp_q.size() != 0 && $urandom_range(0, 9) == 0) begin
          start = 1'b1;
          key_in = {$urandom, $urandom, $urandom, $urandom};
        end else begin
          start = 1'b0;
        end
        c++;
      end
      start = 1'b0;
      check("rand_done_timeout", 132'(done_count != d0), 132'(1));
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    check("queue_drained", 132'(exp_q.size()), 132'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
